fb_req_arbiter: RTL
===================

Name: fb_req_arbiter

Overview:
- Arbitrates DDR2 frame-buffer access between two requesters: display line-buffer refills (reads) and fractal-engine pixel-row writebacks (writes).
- Sits between the display block's row-read request and the fractal compute writer on one side, and the frame buffer's single request port on the other.
- Holds all requests until MIG init completes.
- Serialises accesses so only one is outstanding, and enforces read priority with bounded write starvation and a completion timeout.

Parameters:
- ROW_W, 13, DDR2 row address width
- STARVE_LIM, 4, consecutive read grants allowed while a write is pending before one write is forced
- TIMEOUT, 1023, maximum mem_clk0 cycles from grant to fb_done before abort

Ports:
- mem_clk0  in  1  frame-buffer/MIG user clock; sole clock
- mem_rst_s_n  in  1  synchronous active-low reset
- mig_init_done  in  1  MIG calibration complete (level)
- disp_rd_req  in  1  single-cycle pulse: refill line buffer from row disp_rd_row
- disp_rd_row  in  ROW_W  row for the read; sampled on the disp_rd_req cycle
- disp_rd_done  out  1  single-cycle pulse: requested read completed
- frac_wr_req  in  1  level: write pending; held until frac_wr_ack
- frac_wr_row  in  ROW_W  row for the write; stable while frac_wr_req is high
- frac_wr_ack  out  1  single-cycle pulse: write completed
- fb_req  out  1  request to frame buffer; held until fb_gnt
- fb_we  out  1  1 = write, 0 = read; valid while fb_req is high
- fb_row  out  ROW_W  row address; valid while fb_req is high
- fb_gnt  in  1  frame buffer accepted the request
- fb_done  in  1  frame buffer finished the transfer (pulse)
- rd_overrun  out  1  sticky: disp_rd_req arrived while a read was already pending
- fb_timeout  out  1  sticky: fb_done not seen within TIMEOUT cycles

Behaviour:
- Reset values: all outputs 0. State IDLE. Pending read flag, starve counter and timeout counter all 0.
- Read latch:
  - disp_rd_req sets rd_pend and captures disp_rd_row into rd_row_q.
  - If rd_pend is already set (and not being cleared this cycle), rd_overrun is set and the new row overwrites rd_row_q (latest row wins).
  - rd_pend clears on that read's fb_gnt.
- States: IDLE, ISSUE, WAIT.
- IDLE, with mig_init_done=1 required:
  - A write is chosen if frac_wr_req=1 and (rd_pend=0 or starve_cnt==STARVE_LIM).
  - Otherwise a read is chosen if rd_pend=1.
  - On a choice: register fb_we, fb_row and the selected source, then go to ISSUE.
  - If mig_init_done=0, remain in IDLE regardless of requests. A pending read is kept.
- ISSUE:
  - fb_req=1.
  - On fb_gnt: deassert fb_req next cycle, clear the timeout counter, go to WAIT.
  - Latency: fb_req rises the cycle after IDLE selection.
- WAIT:
  - The timeout counter increments each cycle.
  - On fb_done: pulse disp_rd_done or frac_wr_ack the following cycle, then return to IDLE.
  - If the counter reaches TIMEOUT first: set fb_timeout, return to IDLE with no done/ack pulse. A write stays requested by the engine. A read is dropped.
- Starvation counter:
  - +1 on each read grant while frac_wr_req=1.
  - Cleared on a write grant, or when frac_wr_req=0.
  - Saturates at STARVE_LIM.
- Simultaneous events:
  - disp_rd_req in the same cycle as fb_gnt for the previous read: the clear wins for the old request and the new request is latched (rd_pend stays 1, no overrun).
  - fb_gnt and fb_done in the same cycle: treated as gnt, then immediate done (WAIT exits next cycle).
- Reset mid-operation: returns to IDLE, drops fb_req, and clears the pending read and both sticky flags.

Optional Feature:
- ARB_STATS_EN defined:
  - 16-bit wrapping counters rd_grant_cnt and wr_grant_cnt, plus a 10-bit max_wait_cnt (largest grant-to-done latency seen).
  - All three are exposed as extra output ports and reset to 0.
- Not defined: the ports are absent and no counter logic is instantiated.

Decomposition:
- Shared package fb_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT}
  - source enum {SRC_RD, SRC_WR}
  - default ROW_W
- One natural sub-module: fb_arb_timeout, a loadable counter with expiry flag.

Test Plan:
- Reset with mig_init_done=0, then a disp_rd_req row 0x005: fb_req stays 0. After mig_init_done rises: fb_req=1, fb_we=0, fb_row=0x005 the next cycle. On fb_gnt then fb_done: exactly one disp_rd_done pulse.
- disp_rd_req row 0x001 and frac_wr_req row 0x100 both pending in IDLE: the read is issued first. The write is issued after disp_rd_done, and frac_wr_ack pulses after its fb_done.
- frac_wr_req held high with 5 back-to-back reads (STARVE_LIM=4): grant order is R,R,R,R,W,R.
- Two disp_rd_req pulses (rows 3 then 7) before fb_gnt: rd_overrun=1 and fb_row=7.
- Grant a write and withhold fb_done for 1023 cycles: fb_timeout=1, no frac_wr_ack, state returns to IDLE. The write reissues while frac_wr_req stays high.
- Assert mem_rst_s_n=0 during WAIT: next cycle all outputs are 0 and the state is IDLE. After release, requests are served normally.

Source files
------------

// File: rtl/fb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fb_arb_pkg
//  Purpose  : Shared types and defaults for the frame-buffer request arbiter.
//             Arbiter states, request source encoding and default row width.
//  Revision : 1.0  initial release
// ============================================================================
package fb_arb_pkg;

  // Default DDR2 row address width.
  localparam int C_ROW_W = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_RD = 1'b0,
    SRC_WR = 1'b1
  } arb_src_e;

endpackage
`default_nettype wire

// File: rtl/fb_arb_timeout.sv
`default_nettype none
// ============================================================================
//  Module   : fb_arb_timeout
//  Purpose  : Loadable up-counter with expiry flag. Used to bound the time
//             between a frame-buffer grant and its completion.
//  Ports    : clk, rst_n (sync, active-low)
//             load    - clear the count to zero (has priority)
//             en      - advance the count by one
//             count   - current count
//             expired - count has reached LIMIT (count holds there)
//  Revision : 1.0  initial release
// ============================================================================
module fb_arb_timeout #(
  parameter int LIMIT = 1023,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] count_d, count_q;

  assign expired = (count_q == CNT_W'(LIMIT));
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_req_arbiter
//  Purpose  : Arbitrates the single frame-buffer request port between display
//             line-buffer refills (reads) and fractal-engine row writebacks
//             (writes). One access outstanding at a time, reads preferred,
//             writes forced after STARVE_LIM consecutive read grants, and an
//             access is abandoned if fb_done does not arrive within TIMEOUT
//             cycles of its grant. Nothing is issued before MIG init is done.
//  Ports    : mem_clk0 / mem_rst_s_n (sync, active-low), mig_init_done
//             disp_rd_req/_row -> disp_rd_done   (read requester)
//             frac_wr_req/_row -> frac_wr_ack    (write requester)
//             fb_req/fb_we/fb_row <- fb_gnt/fb_done (frame-buffer port)
//             rd_overrun, fb_timeout             (sticky error flags)
//  Options  : ARB_STATS_EN adds rd_grant_cnt, wr_grant_cnt (16-bit wrapping)
//             and max_wait_cnt (10-bit, worst grant-to-done latency).
//  Revision : 1.0  initial release
// ============================================================================
module fb_req_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ROW_W      = C_ROW_W,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic             mem_clk0,
  input  logic             mem_rst_s_n,
  input  logic             mig_init_done,
  input  logic             disp_rd_req,
  input  logic [ROW_W-1:0] disp_rd_row,
  output logic             disp_rd_done,
  input  logic             frac_wr_req,
  input  logic [ROW_W-1:0] frac_wr_row,
  output logic             frac_wr_ack,
  output logic             fb_req,
  output logic             fb_we,
  output logic [ROW_W-1:0] fb_row,
  input  logic             fb_gnt,
  input  logic             fb_done,
  output logic             rd_overrun,
  output logic             fb_timeout
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]      rd_grant_cnt,
  output logic [15:0]      wr_grant_cnt,
  output logic [9:0]       max_wait_cnt
`endif
);

  localparam int SC_W  = $clog2(STARVE_LIM + 1);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e       state_d, state_q;
  arb_src_e         src_d, src_q;
  logic             fb_we_d, fb_we_q;
  logic [ROW_W-1:0] fb_row_d, fb_row_q;
  logic             rd_pend_d, rd_pend_q;
  logic [ROW_W-1:0] rd_row_d, rd_row_q;
  logic [SC_W-1:0]  starve_d, starve_q;
  logic             rd_done_d, rd_done_q;
  logic             wr_ack_d, wr_ack_q;
  logic             overrun_d, overrun_q;
  logic             timeout_d, timeout_q;
  // fb_done seen together with fb_gnt; lets WAIT exit on its first cycle.
  logic             early_d, early_q;

  logic             tmr_load, tmr_en, tmr_expired;
  logic [CNT_W-1:0] tmr_count;

  logic             rd_gnt, wr_gnt, starve_sat;
  logic [ROW_W-1:0] rd_row_new;

  assign rd_gnt     = (state_q == ISSUE) && fb_gnt && (src_q == SRC_RD);
  assign wr_gnt     = (state_q == ISSUE) && fb_gnt && (src_q == SRC_WR);
  assign starve_sat = (starve_q == SC_W'(STARVE_LIM));
  // Latest row wins: a request arriving this cycle supersedes the latched row.
  assign rd_row_new = disp_rd_req ? disp_rd_row : rd_row_q;

  fb_arb_timeout #(
    .LIMIT (TIMEOUT),
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk     (mem_clk0),
    .rst_n   (mem_rst_s_n),
    .load    (tmr_load),
    .en      (tmr_en),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    fb_we_d   = fb_we_q;
    fb_row_d  = fb_row_q;
    rd_pend_d = rd_pend_q;
    rd_row_d  = rd_row_q;
    starve_d  = starve_q;
    rd_done_d = 1'b0;
    wr_ack_d  = 1'b0;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    early_d   = early_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mig_init_done) begin
          if (frac_wr_req && (!rd_pend_q || starve_sat)) begin
            src_d    = SRC_WR;
            fb_we_d  = 1'b1;
            fb_row_d = frac_wr_row;
            state_d  = ISSUE;
          end else if (rd_pend_q) begin
            src_d    = SRC_RD;
            fb_we_d  = 1'b0;
            fb_row_d = rd_row_new;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (fb_gnt) begin
          state_d  = WAIT;
          tmr_load = 1'b1;
          early_d  = fb_done;
        end else if ((src_q == SRC_RD) && disp_rd_req) begin
          // A newer read row replaces the one still waiting for its grant.
          fb_row_d = disp_rd_row;
        end
      end
      WAIT: begin
        if (fb_done || early_q) begin
          state_d   = IDLE;
          early_d   = 1'b0;
          rd_done_d = (src_q == SRC_RD);
          wr_ack_d  = (src_q == SRC_WR);
        end else if (tmr_expired) begin
          // Abandon silently: a write is re-requested by the engine's held
          // level, a read has already been cleared at its grant.
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!frac_wr_req || wr_gnt) begin
      starve_d = '0;
    end else if (rd_gnt && !starve_sat) begin
      starve_d = starve_q + 1'b1;
    end

    if (disp_rd_req) begin
      if (rd_pend_q && !rd_gnt) begin
        overrun_d = 1'b1;
      end
      rd_pend_d = 1'b1;
      rd_row_d  = disp_rd_row;
    end else if (rd_gnt) begin
      rd_pend_d = 1'b0;
    end
  end

  always_ff @(posedge mem_clk0) begin
    if (!mem_rst_s_n) begin
      state_q   <= IDLE;
      src_q     <= SRC_RD;
      fb_we_q   <= 1'b0;
      fb_row_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_row_q  <= '0;
      starve_q  <= '0;
      rd_done_q <= 1'b0;
      wr_ack_q  <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      early_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      fb_we_q   <= fb_we_d;
      fb_row_q  <= fb_row_d;
      rd_pend_q <= rd_pend_d;
      rd_row_q  <= rd_row_d;
      starve_q  <= starve_d;
      rd_done_q <= rd_done_d;
      wr_ack_q  <= wr_ack_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      early_q   <= early_d;
    end
  end

  assign fb_req       = (state_q == ISSUE);
  assign fb_we        = fb_we_q;
  assign fb_row       = fb_row_q;
  assign disp_rd_done = rd_done_q;
  assign frac_wr_ack  = wr_ack_q;
  assign rd_overrun   = overrun_q;
  assign fb_timeout   = timeout_q;

`ifdef ARB_STATS_EN
  logic [15:0] rd_grant_cnt_d, rd_grant_cnt_q;
  logic [15:0] wr_grant_cnt_d, wr_grant_cnt_q;
  logic [9:0]  max_wait_d, max_wait_q;
  logic [9:0]  wait_now;

  assign wait_now = 10'(tmr_count);

  always_comb begin
    rd_grant_cnt_d = rd_grant_cnt_q + {15'd0, rd_gnt};
    wr_grant_cnt_d = wr_grant_cnt_q + {15'd0, wr_gnt};
    max_wait_d     = max_wait_q;
    if ((state_q == WAIT) && (fb_done || early_q) && (wait_now > max_wait_q)) begin
      max_wait_d = wait_now;
    end
  end

  always_ff @(posedge mem_clk0) begin
    if (!mem_rst_s_n) begin
      rd_grant_cnt_q <= '0;
      wr_grant_cnt_q <= '0;
      max_wait_q     <= '0;
    end else begin
      rd_grant_cnt_q <= rd_grant_cnt_d;
      wr_grant_cnt_q <= wr_grant_cnt_d;
      max_wait_q     <= max_wait_d;
    end
  end

  assign rd_grant_cnt = rd_grant_cnt_q;
  assign wr_grant_cnt = wr_grant_cnt_q;
  assign max_wait_cnt = max_wait_q;
`else
  logic unused_tmr_count;
  assign unused_tmr_count = ^tmr_count;
`endif

endmodule
`default_nettype wire
